nios_system_onchip_copier: RTL

NIOS_SYSTEM_ONCHIP_COPIER -- requirements
Module: nios_system_onchip_copier

---
 rtl/nios_system_onchip_copier.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nios_system_onchip_copier.sv
// -----------------------------------------------------------------------------
// nios_system_onchip_copier
//
// Purpose:
//   Word-granular block mover for an on-chip RAM slave with a fixed read
//   latency of one cycle and no waitrequest. A job either copies `length`
//   words from `src_addr` to `dst_addr` (fill_mode = 0) or writes
//   `fill_data` to `length` words starting at `dst_addr` (fill_mode = 1).
//   Addresses advance in ascending order and wrap modulo 2^ADDR_W. No overlap
//   correction is done, so an overlapping copy behaves like a plain forward
//   word-by-word loop.
//
//   Copy runs RD -> CAP -> WR per word (3 cycles/word); fill stays in WR
//   (1 cycle/word). A zero-length job goes straight to DONE with no RAM
//   access.
//
// Ports:
//   clk           in   single clock
//   reset         in   asynchronous active-high reset
//   start         in   one-cycle job request, sampled only while idle
//   fill_mode     in   0 = copy src->dst, 1 = fill dst with fill_data
//   src_addr      in   first source word address        [ADDR_W]
//   dst_addr      in   first destination word address   [ADDR_W]
//   length        in   word count, 0 .. 2^ADDR_W        [ADDR_W+1]
//   fill_data     in   fill pattern                     [DATA_W]
//   busy          out  high while a job is moving data (RD/CAP/WR)
//   done          out  one-cycle completion pulse
//   m_address     out  RAM word address                 [ADDR_W]
//   m_byteenable  out  RAM byte enables, all ones       [DATA_W/8]
//   m_chipselect  out  RAM chip select
//   m_write       out  RAM write strobe
//   m_writedata   out  RAM write data                   [DATA_W]
//   m_clken       out  RAM clock enable, always one
//   m_readdata    in   RAM read data, valid one cycle after the read
// -----------------------------------------------------------------------------
module nios_system_onchip_copier #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   // job request
   input  logic                  start,
   input  logic                  fill_mode,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [ADDR_W:0]       length,
   input  logic [DATA_W-1:0]     fill_data,
   // job status
   output logic                  busy,
   output logic                  done,
   // RAM slave
   output logic [ADDR_W-1:0]     m_address,
   output logic [DATA_W/8-1:0]   m_byteenable,
   output logic                  m_chipselect,
   output logic                  m_write,
   output logic [DATA_W-1:0]     m_writedata,
   output logic                  m_clken,
   input  logic [DATA_W-1:0]     m_readdata
);

   localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StCap,
      StWr,
      StDone
   } state_e;

   // ---------------------------------------------------------------------------
   // State and job registers
   // ---------------------------------------------------------------------------
   state_e              r_state;
   logic [ADDR_W-1:0]   r_src;
   logic [ADDR_W-1:0]   r_dst;
   logic [ADDR_W:0]     r_count;
   logic                r_fill_mode;
   logic [DATA_W-1:0]   r_fill_data;
   logic [DATA_W-1:0]   r_data;

   state_e              w_state_nxt;
   logic [ADDR_W-1:0]   w_src_nxt;
   logic [ADDR_W-1:0]   w_dst_nxt;
   logic [ADDR_W:0]     w_count_nxt;
   logic                w_fill_mode_nxt;
   logic [DATA_W-1:0]   w_fill_data_nxt;
   logic [DATA_W-1:0]   w_data_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_src       <= '0;
         r_dst       <= '0;
         r_count     <= '0;
         r_fill_mode <= 1'b0;
         r_fill_data <= '0;
         r_data      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_src       <= w_src_nxt;
         r_dst       <= w_dst_nxt;
         r_count     <= w_count_nxt;
         r_fill_mode <= w_fill_mode_nxt;
         r_fill_data <= w_fill_data_nxt;
         r_data      <= w_data_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------
   // All bus outputs are decoded from r_state only, so the asynchronous reset
   // forcing r_state to StIdle clears them immediately.
   always_comb begin
      w_state_nxt     = r_state;
      w_src_nxt       = r_src;
      w_dst_nxt       = r_dst;
      w_count_nxt     = r_count;
      w_fill_mode_nxt = r_fill_mode;
      w_fill_data_nxt = r_fill_data;
      w_data_nxt      = r_data;

      busy            = 1'b0;
      done            = 1'b0;
      m_chipselect    = 1'b0;
      m_write         = 1'b0;
      m_address       = '0;
      m_writedata     = '0;

      unique case (r_state)
         StIdle: begin
            if (start) begin
               // Snapshot the whole request so the caller may change its
               // inputs freely once the job has been accepted.
               w_src_nxt       = src_addr;
               w_dst_nxt       = dst_addr;
               w_count_nxt     = length;
               w_fill_mode_nxt = fill_mode;
               w_fill_data_nxt = fill_data;
               if (length == '0) begin
                  w_state_nxt = StDone;
               end else if (fill_mode) begin
                  w_state_nxt = StWr;
               end else begin
                  w_state_nxt = StRd;
               end
            end
         end

         StRd: begin
            busy         = 1'b1;
            m_chipselect = 1'b1;
            m_address    = r_src;
            w_state_nxt  = StCap;
         end

         StCap: begin
            // Read issued in StRd returns now (latency 1).
            busy        = 1'b1;
            w_data_nxt  = m_readdata;
            w_state_nxt = StWr;
         end

         StWr: begin
            busy         = 1'b1;
            m_chipselect = 1'b1;
            m_write      = 1'b1;
            m_address    = r_dst;
            m_writedata  = r_fill_mode ? r_fill_data : r_data;
            // Address adders wrap naturally at 2^ADDR_W.
            w_src_nxt    = r_src + AddrOne;
            w_dst_nxt    = r_dst + AddrOne;
            w_count_nxt  = r_count - CntOne;
            if (r_count == CntOne) begin
               w_state_nxt = StDone;
            end else if (r_fill_mode) begin
               w_state_nxt = StWr;
            end else begin
               w_state_nxt = StRd;
            end
         end

         StDone: begin
            done        = 1'b1;
            w_state_nxt = StIdle;
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // The slave is always clocked and always written as whole words.
   assign m_clken      = 1'b1;
   assign m_byteenable = '1;

endmodule
